// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with per-register pending-write scoreboard (optional: REGFILE_BYPASS_EN)
module reg_file_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int PEND_W   = 2,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   Issue_Valid,
   input  logic [AW-1:0]          Issue_RD,
   output logic                   Issue_Ready,
   input  logic [NUM_RD*AW-1:0]   RS_Addr,
   input  logic [NUM_RD-1:0]      RS_Valid,
   output logic [NUM_RD*XLEN-1:0] REG_R_Data,
   output logic [NUM_RD-1:0]      RS_Busy,
   output logic                   Stall,
   input  logic                   REG_W_En,
   input  logic [AW-1:0]          REG_W_Addr,
   input  logic [XLEN-1:0]        REG_W_Data,
   output logic                   Underflow_Err
);

   logic [XLEN-1:0]   r_regs  [NUM_REGS];
   logic [PEND_W-1:0] r_count [NUM_REGS];
   logic              r_underflow;

   logic              w_wr_live;
   logic              w_accept;
   logic              w_dec;
   logic              w_underflow;
   logic [AW-1:0]     w_raddr;
   logic [NUM_RD*XLEN-1:0] w_rdata;
   logic [NUM_RD-1:0] w_busy;

   // A writeback to x0 is a no-op for both data and scoreboard.
   assign w_wr_live   = REG_W_En && (REG_W_Addr != '0);
   // A saturated counter blocks further issues to that register; x0 is never tracked.
   assign Issue_Ready = (Issue_RD == '0) || (r_count[Issue_RD] != '1);
   assign w_accept    = Issue_Valid && Issue_Ready && (Issue_RD != '0);
   assign w_dec       = w_wr_live && (r_count[REG_W_Addr] != '0);
   assign w_underflow = w_wr_live && (r_count[REG_W_Addr] == '0);

   // Register data storage; x0 stays hard-wired to zero.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_wr_live) begin
         r_regs[REG_W_Addr] <= REG_W_Data;
      end
   end

   // Pending-write counters: issue increments, writeback decrements, both at once cancel.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_REGS; i++) r_count[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (w_accept && (Issue_RD == AW'(i)) && !(w_dec && (REG_W_Addr == AW'(i))))
               r_count[i] <= r_count[i] + PEND_W'(1);
            else if (w_dec && (REG_W_Addr == AW'(i)) && !(w_accept && (Issue_RD == AW'(i))))
               r_count[i] <= r_count[i] - PEND_W'(1);
         end
      end
   end

   // Sticky flag for a writeback that had no matching outstanding issue.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         r_underflow <= 1'b0;
      else if (w_underflow)
         r_underflow <= 1'b1;
   end

   // Combinational read ports and RAW hazard detection; nothing here looks at Issue_*.
   always_comb begin
      w_rdata = '0;
      w_busy  = '0;
      w_raddr = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         w_raddr = RS_Addr[p*AW +: AW];
         if (w_raddr != '0)
            w_rdata[p*XLEN +: XLEN] = r_regs[w_raddr];
         w_busy[p] = RS_Valid[p] && (w_raddr != '0) && (r_count[w_raddr] != '0);
`ifdef REGFILE_BYPASS_EN
         // Forward the in-flight writeback; the hazard clears if it retires the last pending write.
         if (w_wr_live && (REG_W_Addr == w_raddr))
            w_rdata[p*XLEN +: XLEN] = REG_W_Data;
         if (w_dec && (REG_W_Addr == w_raddr) && (r_count[w_raddr] == PEND_W'(1)))
            w_busy[p] = 1'b0;
`else
         // Stored values only; a same-cycle writeback is seen after the edge.
`endif
      end
   end

   assign REG_R_Data    = w_rdata;
   assign RS_Busy       = w_busy;
   assign Stall         = |w_busy;
   assign Underflow_Err = r_underflow;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int PW   = 2;
   localparam int AW   = 5;

   logic                CLK = 1'b0;
   logic                RST_N;
   logic                Issue_Valid;
   logic [AW-1:0]       Issue_RD;
   logic                Issue_Ready;
   logic [NRD*AW-1:0]   RS_Addr;
   logic [NRD-1:0]      RS_Valid;
   logic [NRD*XLEN-1:0] REG_R_Data;
   logic [NRD-1:0]      RS_Busy;
   logic                Stall;
   logic                REG_W_En;
   logic [AW-1:0]       REG_W_Addr;
   logic [XLEN-1:0]     REG_W_Data;
   logic                Underflow_Err;

   int n_vec = 0;
   int n_err = 0;

   reg_file_scoreboard #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD(NRD), .PEND_W(PW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .Issue_Valid(Issue_Valid), .Issue_RD(Issue_RD), .Issue_Ready(Issue_Ready),
      .RS_Addr(RS_Addr), .RS_Valid(RS_Valid), .REG_R_Data(REG_R_Data),
      .RS_Busy(RS_Busy), .Stall(Stall),
      .REG_W_En(REG_W_En), .REG_W_Addr(REG_W_Addr), .REG_W_Data(REG_W_Data),
      .Underflow_Err(Underflow_Err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      Issue_Valid = 1'b0;
      REG_W_En    = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0; Issue_Valid = 1'b0; Issue_RD = '0;
      RS_Addr = {5'd5, 5'd3}; RS_Valid = 2'b11;
      REG_W_En = 1'b0; REG_W_Addr = '0; REG_W_Data = '0;
      #12;
      chk("rst_data",   REG_R_Data, 64'h0);
      chk("rst_busy",   RS_Busy, 2'b00);
      chk("rst_stall",  Stall, 1'b0);
      chk("rst_ready",  Issue_Ready, 1'b1);
      chk("rst_uflow",  Underflow_Err, 1'b0);
      RST_N = 1'b1;

      // issue x7, then read it back through writeback
      tick();
      Issue_Valid = 1'b1; Issue_RD = 5'd7;
      #1 chk("x7_ready", Issue_Ready, 1'b1);
      tick();
      idle();
      RS_Addr = {5'd0, 5'd7}; RS_Valid = 2'b01;
      #1 chk("x7_busy", RS_Busy, 2'b01);
      chk("x7_stall", Stall, 1'b1);
      REG_W_En = 1'b1; REG_W_Addr = 5'd7; REG_W_Data = 32'hDEADBEEF;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("x7_wb_busy", RS_Busy, 2'b00);
      chk("x7_wb_data", REG_R_Data[31:0], 32'hDEADBEEF);
`else
      chk("x7_wb_busy", RS_Busy, 2'b01);
      chk("x7_wb_data", REG_R_Data[31:0], 32'h0);
`endif
      tick();
      idle();
      #1 chk("x7_after_busy", RS_Busy, 2'b00);
      chk("x7_after_data", REG_R_Data[31:0], 32'hDEADBEEF);

      // saturate x4
      Issue_Valid = 1'b1; Issue_RD = 5'd4;
      tick(); tick(); tick();
      #1 chk("x4_full_ready", Issue_Ready, 1'b0);
      Issue_RD = 5'd5;
      #1 chk("x5_ready", Issue_Ready, 1'b1);
      Issue_RD = 5'd4; Issue_Valid = 1'b0;
      REG_W_En = 1'b1; REG_W_Addr = 5'd4; REG_W_Data = 32'h44;
      #1 chk("x4_ready_ignores_wb", Issue_Ready, 1'b0);
      tick();
      idle();
      #1 chk("x4_ready_after_wb", Issue_Ready, 1'b1);
      // issue + writeback same cycle: count stays 2
      Issue_Valid = 1'b1; REG_W_En = 1'b1;
      tick();
      idle();
      RS_Addr = {5'd0, 5'd4}; RS_Valid = 2'b01;
      #1 chk("x4_same_ready", Issue_Ready, 1'b1);
      chk("x4_same_busy", RS_Busy, 2'b01);
      REG_W_En = 1'b1;
      tick();
      idle();
      #1 chk("x4_cnt1_busy", RS_Busy, 2'b01);
      REG_W_En = 1'b1;
      tick();
      idle();
      #1 chk("x4_cnt0_busy", RS_Busy, 2'b00);
      chk("x4_uflow", Underflow_Err, 1'b0);

      // x0 is never tracked nor written
      Issue_Valid = 1'b1; Issue_RD = 5'd0;
      REG_W_En = 1'b1; REG_W_Addr = 5'd0; REG_W_Data = 32'h1234;
      RS_Addr = {5'd0, 5'd0}; RS_Valid = 2'b11;
      #1 chk("x0_ready", Issue_Ready, 1'b1);
      chk("x0_busy", RS_Busy, 2'b00);
      chk("x0_data", REG_R_Data, 64'h0);
      tick();
      idle();
      #1 chk("x0_data_after", REG_R_Data, 64'h0);
      chk("x0_busy_after", RS_Busy, 2'b00);
      chk("x0_uflow", Underflow_Err, 1'b0);

      // underflow on x9
      REG_W_En = 1'b1; REG_W_Addr = 5'd9; REG_W_Data = 32'h99;
      tick();
      idle();
      RS_Addr = {5'd0, 5'd9}; RS_Valid = 2'b01;
      #1 chk("x9_uflow", Underflow_Err, 1'b1);
      chk("x9_data", REG_R_Data[31:0], 32'h99);
      chk("x9_busy", RS_Busy, 2'b00);
      tick();
      chk("x9_uflow_sticky", Underflow_Err, 1'b1);
      Issue_Valid = 1'b1; Issue_RD = 5'd9;
      tick();
      idle();
      #1 chk("x9_issue_busy", RS_Busy, 2'b01);
      REG_W_En = 1'b1; REG_W_Addr = 5'd9; REG_W_Data = 32'h98;
      tick();
      idle();
      #1 chk("x9_cnt_was0", RS_Busy, 2'b00);

      // async reset mid-cycle with x2 count 2
      Issue_Valid = 1'b1; Issue_RD = 5'd2;
      tick(); tick();
      idle();
      RS_Addr = {5'd7, 5'd2}; RS_Valid = 2'b11;
      #1 chk("x2_busy", RS_Busy, 2'b01);
      chk("x7_kept", REG_R_Data[63:32], 32'hDEADBEEF);
      @(negedge CLK);
      #2 RST_N = 1'b0;
      #1 chk("arst_busy", RS_Busy, 2'b00);
      chk("arst_stall", Stall, 1'b0);
      chk("arst_data", REG_R_Data, 64'h0);
      chk("arst_uflow", Underflow_Err, 1'b0);
      chk("arst_ready", Issue_Ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
